// File: rtl/video_scan_out.sv
// video_scan_out: raster timing generator and pixel scan-out engine.
//
// Walks an H_TOTAL x V_TOTAL raster. In the visible area it fetches one
// 32-bit word every 4 pixels from video memory. It then serialises the word
// LSB-byte first onto pixel. The timing terms (visible, hsync, vsync, irq)
// go through a 3-stage delay so they line up with the fetched pixel data.
//
// Ports
//   clk           pixel/system clock, rising edge
//   rst           asynchronous reset, active low
//   enable        scan-out enable; low clears counters and delay pipeline
//   video_address byte address to memory read port (word aligned)
//   video_data    memory read data, valid in the 2nd cycle after an address change
//   pixel         pixel byte, 0 outside the visible area
//   pixel_valid   data enable (visible area)
//   hsync, vsync  active-low syncs
//   vblank_irq    one-cycle pulse at start of vertical blanking
module video_scan_out #(
    parameter int H_VISIBLE = 128,
    parameter int H_FRONT   = 8,
    parameter int H_SYNC    = 16,
    parameter int H_BACK    = 8,
    parameter int V_VISIBLE = 64,
    parameter int V_FRONT   = 2,
    parameter int V_SYNC    = 4,
    parameter int V_BACK    = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic [12:0] video_address,
    input  logic [31:0] video_data,
    output logic [7:0]  pixel,
    output logic        pixel_valid,
    output logic        hsync,
    output logic        vsync,
    output logic        vblank_irq
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int STAGES  = 3;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS  = HW'(H_VISIBLE);
    localparam logic [HW-1:0] H_SS   = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] H_SE   = HW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS  = VW'(V_VISIBLE);
    localparam logic [VW-1:0] V_SS   = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] V_SE   = VW'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [HW-1:0]     h_count;
    logic [VW-1:0]     v_count;
    logic [10:0]       word_count;
    logic [31:0]       shift_reg;
    logic [STAGES:1]   vld_pipe;
    logic [STAGES:1]   hs_pipe;
    logic [STAGES:1]   vs_pipe;
    logic [STAGES:1]   irq_pipe;
    logic [2:1]        fetch_pipe;

    logic              visible;
    logic              fetch;
    logic              hs_term;
    logic              vs_term;
    logic              irq_term;
    logic [10:0]       word_cur;

    always_comb begin
        visible  = (h_count < H_VIS) && (v_count < V_VIS);
        fetch    = visible && (h_count[1:0] == 2'b00);
        hs_term  = (h_count >= H_SS) && (h_count < H_SE);
        vs_term  = (v_count >= V_SS) && (v_count < V_SE);
        irq_term = (h_count == '0) && (v_count == V_VIS);
        // The word counter restarts at the top of every frame; the first
        // fetch of the frame must already use the cleared value.
        word_cur = ((h_count == '0) && (v_count == '0)) ? 11'd0 : word_count;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_count       <= '0;
            v_count       <= '0;
            word_count    <= '0;
            video_address <= '0;
            shift_reg     <= '0;
            vld_pipe      <= '0;
            hs_pipe       <= '0;
            vs_pipe       <= '0;
            irq_pipe      <= '0;
            fetch_pipe    <= '0;
        end else if (!enable) begin
            // Abort: video_address and shift_reg keep their last values.
            h_count    <= '0;
            v_count    <= '0;
            word_count <= '0;
            vld_pipe   <= '0;
            hs_pipe    <= '0;
            vs_pipe    <= '0;
            irq_pipe   <= '0;
            fetch_pipe <= '0;
        end else begin
            if (h_count == H_LAST) begin
                h_count <= '0;
                v_count <= (v_count == V_LAST) ? '0 : v_count + VW'(1);
            end else begin
                h_count <= h_count + HW'(1);
            end

            if (fetch) begin
                video_address <= {word_cur, 2'b00};
                word_count    <= word_cur + 11'd1;
            end else begin
                word_count    <= word_cur;
            end

            vld_pipe   <= {vld_pipe[STAGES-1:1], visible};
            hs_pipe    <= {hs_pipe[STAGES-1:1], hs_term};
            vs_pipe    <= {vs_pipe[STAGES-1:1], vs_term};
            irq_pipe   <= {irq_pipe[STAGES-1:1], irq_term};
            fetch_pipe <= {fetch_pipe[1], fetch};

            // Read data for the fetch at 4k is valid during 4k+2; load it
            // then, otherwise shift the next byte down into [7:0].
            if (fetch_pipe[2])
                shift_reg <= video_data;
            else
                shift_reg <= {8'h00, shift_reg[31:8]};
        end
    end

    assign pixel_valid = vld_pipe[STAGES];
    assign pixel       = vld_pipe[STAGES] ? shift_reg[7:0] : 8'h00;
    assign hsync       = ~hs_pipe[STAGES];
    assign vsync       = ~vs_pipe[STAGES];
    assign vblank_irq  = irq_pipe[STAGES];

endmodule
